farbwechsel_ctrl: RTL and testbench

Frame-synchronous colour-change controller for the Pong display. It steps the ball/paddle colour through a fixed 7-entry palette once every N video frames. N is shortened while `turbo` is asserted, and a ball-hit event can force an extra step. Every change is applied only on a frame boundary, so the VGA output never tears mid-frame. The block sits between the VGA timing generator (source of `frame_tick`) and the pixel colour mux (consumer of `rgb`).

---
 rtl/farbwechsel_ctrl_if.sv | 35 +++
 rtl/farbwechsel_ctrl.sv | 116 +++++++++++
 tb/tb_farbwechsel_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/farbwechsel_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : farbwechsel_ctrl_if
// Description : Control/colour bundle between the frame source and the
//               colour-change controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface farbwechsel_ctrl_if;
    logic       enable;
    logic       turbo;
    logic       frame_tick;
    logic       hit;
    logic [2:0] rgb;
    logic       change;

    modport master (
        output enable,
        output turbo,
        output frame_tick,
        output hit,
        input  rgb,
        input  change
    );

    modport slave (
        input  enable,
        input  turbo,
        input  frame_tick,
        input  hit,
        output rgb,
        output change
    );
endinterface
`default_nettype wire

// File: rtl/farbwechsel_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : farbwechsel_ctrl
// Description : Steps the Pong colour through a 7-entry palette every N
//               frames; hits force an extra step, applied on frame_tick only.
// Revision    : 1.0 - initial release
// ============================================================================
module farbwechsel_ctrl #(
    parameter int FRAMES_NORMAL = 60,
    parameter int FRAMES_TURBO  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    farbwechsel_ctrl_if.slave    bus
);

    localparam logic [7:0] c_normal_m1 = 8'(FRAMES_NORMAL - 1);
    localparam logic [7:0] c_turbo_m1  = 8'(FRAMES_TURBO - 1);
    localparam logic [2:0] c_rgb_reset = 3'b111;
    localparam logic [2:0] c_rgb_first = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_ARMED = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_fcnt;
    logic [7:0] w_fcnt_nxt;
    logic [2:0] r_rgb;
    logic       r_change;
    logic       r_hit_d;
    logic       w_hit_req;
    logic       w_step;
    logic [7:0] w_period_m1;

    // A held hit is one request: only its first cycle counts.
    assign w_hit_req   = bus.hit & ~r_hit_d;
    assign w_period_m1 = bus.turbo ? c_turbo_m1 : c_normal_m1;

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_fcnt_nxt = 8'd0;
                if (bus.enable) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!bus.enable) begin
                    w_state_nxt = S_IDLE;
                    w_fcnt_nxt  = 8'd0;
                end else if (bus.frame_tick) begin
                    // >= so a turbo switch past the new period steps at once
                    if (w_hit_req || (r_fcnt >= w_period_m1)) begin
                        w_step     = 1'b1;
                        w_fcnt_nxt = 8'd0;
                    end else begin
                        w_fcnt_nxt = r_fcnt + 8'd1;
                    end
                end else if (w_hit_req) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!bus.enable) begin
                    w_state_nxt = S_IDLE;
                    w_fcnt_nxt  = 8'd0;
                end else if (bus.frame_tick) begin
                    w_step      = 1'b1;
                    w_fcnt_nxt  = 8'd0;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_fcnt_nxt  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fcnt   <= 8'd0;
            r_rgb    <= c_rgb_reset;
            r_change <= 1'b0;
            r_hit_d  <= 1'b0;
        end else begin
            r_fcnt   <= w_fcnt_nxt;
            r_change <= w_step;
            r_hit_d  <= bus.hit;
            if (w_step) begin
                r_rgb <= (r_rgb == 3'b111) ? c_rgb_first : (r_rgb + 3'd1);
            end
        end
    end

    assign bus.rgb    = r_rgb;
    assign bus.change = r_change;

endmodule
`default_nettype wire

// File: tb/tb_farbwechsel_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_farbwechsel_ctrl
// Description : Self-checking bench; two controller instances with different
//               periods share one stimulus stream and one reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_farbwechsel_ctrl;

    localparam int NA  = 4;
    localparam int TA  = 2;
    localparam int NB  = 60;
    localparam int TBP = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0;
    logic en = 1'b0;
    logic tu = 1'b0;
    logic ft = 1'b0;
    logic hi = 1'b0;

    farbwechsel_ctrl_if ifa ();
    farbwechsel_ctrl_if ifb ();

    assign ifa.enable     = en;
    assign ifa.turbo      = tu;
    assign ifa.frame_tick = ft;
    assign ifa.hit        = hi;
    assign ifb.enable     = en;
    assign ifb.turbo      = tu;
    assign ifb.frame_tick = ft;
    assign ifb.hit        = hi;

    farbwechsel_ctrl #(.FRAMES_NORMAL(NA), .FRAMES_TURBO(TA)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifa)
    );

    farbwechsel_ctrl #(.FRAMES_NORMAL(NB), .FRAMES_TURBO(TBP)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifb)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: palette index, ticks since last step, pending hit.
    int m_idx  [2] = '{6, 6};
    int m_cnt  [2] = '{0, 0};
    int m_chg  [2] = '{0, 0};
    bit m_run  [2] = '{1'b0, 1'b0};
    bit m_pend [2] = '{1'b0, 1'b0};
    bit m_hprev = 1'b0;
    int per_n  [2] = '{NA, NB};
    int per_t  [2] = '{TA, TBP};

    function automatic logic [2:0] pal(input int i);
        return 3'(i + 1);
    endfunction

    task automatic model_update();
        bit rise;
        int p;
        rise = hi && !m_hprev;
        for (int k = 0; k < 2; k++) begin
            m_chg[k] = 0;
            if (!reset_n) begin
                m_idx[k] = 6; m_cnt[k] = 0; m_pend[k] = 0; m_run[k] = 0;
            end else if (!m_run[k]) begin
                if (en) begin
                    m_run[k] = 1; m_cnt[k] = 0; m_pend[k] = 0;
                end
            end else if (!en) begin
                m_run[k] = 0; m_cnt[k] = 0; m_pend[k] = 0;
            end else if (ft) begin
                p = tu ? per_t[k] : per_n[k];
                if (m_pend[k] || rise || (m_cnt[k] + 1 >= p)) begin
                    m_idx[k] = (m_idx[k] + 1) % 7;
                    m_chg[k] = 1; m_cnt[k] = 0; m_pend[k] = 0;
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end else if (rise) begin
                m_pend[k] = 1;
            end
        end
        m_hprev = reset_n ? hi : 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic logic [7:0] obs();
        return {ifa.rgb, ifa.change, ifb.rgb, ifb.change};
    endfunction

    function automatic logic [7:0] expv();
        return {pal(m_idx[0]), 1'(m_chg[0]), pal(m_idx[1]), 1'(m_chg[1])};
    endfunction

    task automatic apply_reset();
        reset_n = 1'b0; en = 1'b0; tu = 1'b0; ft = 1'b0; hi = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b0; ft = 1'b0; hi = 1'b0; tu = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_cmp++;
            if ({ifa.rgb, ifa.change, ifb.rgb, ifb.change} !== 8'b1110_1110) begin
                n_bad++;
                $display("FAIL reset_state got=%b exp=%b", obs(), 8'b1110_1110);
            end
        end
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ft = 1'b1; hi = 1'($urandom_range(0, 1));
            cyc();
            ft = 1'b0; hi = 1'b0;
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL idle_tick i=%0d got=%h exp=%h", i, obs(), expv());
            end
            cyc();
        end
        n_cmp++;
        if (ifa.rgb !== 3'b111 || ifb.rgb !== 3'b111) begin
            n_bad++;
            $display("FAIL idle_hold got=%b/%b exp=111", ifa.rgb, ifb.rgb);
        end
    endtask

    task automatic test_normal_cycle();
        logic [2:0] exp_seq [8] = '{3'b001, 3'b010, 3'b011, 3'b100,
                                   3'b101, 3'b110, 3'b111, 3'b001};
        apply_reset();
        en = 1'b1;
        cyc();
        for (int i = 0; i < 32; i++) begin
            repeat ($urandom_range(1, 4)) begin
                cyc();
                n_cmp++;
                if (obs() !== expv()) begin
                    n_bad++;
                    $display("FAIL normal_gap i=%0d got=%h exp=%h", i, obs(), expv());
                end
            end
            ft = 1'b1;
            cyc();
            ft = 1'b0;
            n_cmp++;
            if (ifa.change !== ((i % 4) == 3)) begin
                n_bad++;
                $display("FAIL normal_change i=%0d got=%b exp=%b", i, ifa.change, (i % 4) == 3);
            end
            if ((i % 4) == 3) begin
                n_cmp++;
                if (ifa.rgb !== exp_seq[i / 4]) begin
                    n_bad++;
                    $display("FAIL normal_rgb i=%0d got=%b exp=%b", i, ifa.rgb, exp_seq[i / 4]);
                end
            end
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL normal_model i=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_turbo_overshoot();
        apply_reset();
        en = 1'b1;
        cyc();
        for (int i = 0; i < 20; i++) begin
            ft = 1'b1; cyc(); ft = 1'b0;
            n_cmp++;
            if (ifb.change !== 1'b0) begin
                n_bad++;
                $display("FAIL turbo_pre i=%0d got=%b exp=0", i, ifb.change);
            end
            cyc();
        end
        tu = 1'b1;
        cyc();
        for (int j = 0; j < 17; j++) begin
            ft = 1'b1; cyc(); ft = 1'b0;
            n_cmp++;
            if (ifb.change !== ((j % 8) == 0)) begin
                n_bad++;
                $display("FAIL turbo_step j=%0d got=%b exp=%b", j, ifb.change, (j % 8) == 0);
            end
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL turbo_model j=%0d got=%h exp=%h", j, obs(), expv());
            end
            cyc();
        end
        tu = 1'b0;
    endtask

    task automatic test_hit();
        apply_reset();
        en = 1'b1;
        cyc();
        repeat (2) begin ft = 1'b1; cyc(); ft = 1'b0; cyc(); end
        repeat (4) begin hi = 1'b1; cyc(); hi = 1'b0; cyc(); end
        ft = 1'b1; cyc(); ft = 1'b0;
        n_cmp++;
        if ({ifa.change, ifb.change} !== 2'b11 || ifa.rgb !== 3'b001) begin
            n_bad++;
            $display("FAIL hit_step got=%b%b rgb=%b exp=11 rgb=001", ifa.change, ifb.change, ifa.rgb);
        end
        cyc();
        n_cmp++;
        if (ifa.change !== 1'b0) begin
            n_bad++;
            $display("FAIL hit_single got=%b exp=0", ifa.change);
        end
        for (int j = 0; j < 4; j++) begin
            ft = 1'b1; cyc(); ft = 1'b0;
            n_cmp++;
            if ({ifa.change, ifb.change} !== {1'(j == 3), 1'b0}) begin
                n_bad++;
                $display("FAIL hit_restart j=%0d got=%b%b exp=%b0", j, ifa.change, ifb.change, j == 3);
            end
            cyc();
        end
        ft = 1'b1; hi = 1'b1; cyc(); ft = 1'b0; hi = 1'b0;
        n_cmp++;
        if (ifa.change !== 1'b1 || ifa.rgb !== 3'b011) begin
            n_bad++;
            $display("FAIL hit_coincident got=%b rgb=%b exp=1 rgb=011", ifa.change, ifa.rgb);
        end
        cyc();
        ft = 1'b1; cyc(); ft = 1'b0;
        n_cmp++;
        if (ifa.change !== 1'b0) begin
            n_bad++;
            $display("FAIL hit_no_extra got=%b exp=0", ifa.change);
        end
        n_cmp++;
        if (obs() !== expv()) begin
            n_bad++;
            $display("FAIL hit_model got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_disable();
        apply_reset();
        en = 1'b1;
        cyc();
        ft = 1'b1; cyc(); ft = 1'b0;
        hi = 1'b1; cyc(); hi = 1'b0;
        en = 1'b0; cyc();
        ft = 1'b1; cyc(); ft = 1'b0;
        n_cmp++;
        if (ifa.change !== 1'b0 || ifa.rgb !== 3'b111) begin
            n_bad++;
            $display("FAIL disable_hold got=%b rgb=%b exp=0 rgb=111", ifa.change, ifa.rgb);
        end
        en = 1'b1; ft = 1'b1; cyc(); ft = 1'b0;
        cyc();
        for (int j = 0; j < 4; j++) begin
            ft = 1'b1; cyc(); ft = 1'b0;
            n_cmp++;
            if (ifa.change !== (j == 3)) begin
                n_bad++;
                $display("FAIL reenable_period j=%0d got=%b exp=%b", j, ifa.change, j == 3);
            end
            cyc();
        end
    endtask

    task automatic test_reset_armed();
        int guard;
        apply_reset();
        en = 1'b1;
        cyc();
        guard = 0;
        while (m_idx[0] != 3 && guard < 100) begin
            ft = 1'b1; cyc(); ft = 1'b0; cyc();
            guard++;
        end
        n_cmp++;
        if (ifa.rgb !== 3'b100) begin
            n_bad++;
            $display("FAIL armed_setup got=%b exp=100", ifa.rgb);
        end
        hi = 1'b1; cyc(); hi = 1'b0; cyc();
        reset_n = 1'b0; ft = 1'b1; hi = 1'b1;
        cyc();
        ft = 1'b0; hi = 1'b0; reset_n = 1'b1;
        n_cmp++;
        if (ifa.rgb !== 3'b111 || ifa.change !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_armed got=%b/%b exp=111/0", ifa.rgb, ifa.change);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 99) < 95);
            if ($urandom_range(0, 49) == 0) tu = ~tu;
            ft = ($urandom_range(0, 3) == 0);
            hi = hi ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
            reset_n = ($urandom_range(0, 499) != 0);
            cyc();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL random i=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
        reset_n = 1'b1; ft = 1'b0; hi = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal_cycle();
        test_turbo_overshoot();
        test_hit();
        test_disable();
        test_reset_armed();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
